// File: rtl/poly_mult_harness.sv
// Switch-driven loader and one-term-per-clock schoolbook multiplier over Z_(2^W)[x]/(x^N -/+ 1).
// Result coefficients are browsed on the LEDs once the product is complete.
module poly_mult_harness #(
  parameter int N    = 4,
  parameter int W    = 4,
  parameter int NEGA = 0
) (
  input  logic        man_clk,
  input  logic        man_reset,
  input  logic [15:0] bits,
  input  logic        load,
  output logic [15:0] LED,
  output logic        done
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] ONE   = IW'(1);
  localparam logic [IW:0]   N_EXT = (IW + 1)'(N);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_MAC    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic          load_q;
  logic          ld_edge;
  logic [IW-1:0] idx, i, j;
  logic [W-1:0]  a [N];
  logic [W-1:0]  b [N];
  logic [W-1:0]  r [N];

  logic [IW:0]   s;
  logic          wrap;
  logic [IW-1:0] k;
  logic [IW-1:0] sel;
  logic [W-1:0]  prod;
  logic          idx_last;
  logic          mac_last;

  assign ld_edge  = load & ~load_q;
  assign idx_last = (idx == LAST);
  assign mac_last = (i == LAST) && (j == LAST);

  // Term index folded back into 0..N-1; wrap marks terms that passed x^N.
  assign s    = {1'b0, i} + {1'b0, j};
  assign wrap = (s >= N_EXT);
  assign k    = wrap ? IW'(s - N_EXT) : IW'(s);
  assign prod = a[i] * b[j];
  assign sel  = IW'({1'b0, bits[11:8]} % 5'(N));

  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      state  <= S_INIT;
      done   <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= (state_next == S_DONE);
      load_q <= load;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   state_next = S_LOAD_A;
      S_LOAD_A: if (ld_edge && idx_last) state_next = S_LOAD_B;
      S_LOAD_B: if (ld_edge && idx_last) state_next = S_MAC;
      S_MAC:    if (mac_last) state_next = S_DONE;
      S_DONE:   if (ld_edge) state_next = S_LOAD_A;
      default:  state_next = S_INIT;
    endcase
  end

  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      LED <= 16'h0000;
      idx <= '0;
      i   <= '0;
      j   <= '0;
      for (int n = 0; n < N; n++) begin
        a[n] <= '0;
        b[n] <= '0;
        r[n] <= '0;
      end
    end else begin
      case (state)
        S_INIT: begin
          LED <= 16'hFFFF;
          idx <= '0;
          i   <= '0;
          j   <= '0;
        end
        S_LOAD_A: begin
          LED <= {4'h1, 4'(idx), 8'(bits[W-1:0])};
          if (ld_edge) begin
            a[idx] <= bits[W-1:0];
            idx    <= idx_last ? '0 : idx + ONE;
          end
        end
        S_LOAD_B: begin
          LED <= {4'h2, 4'(idx), 8'(bits[W-1:0])};
          if (ld_edge) begin
            b[idx] <= bits[W-1:0];
            if (idx_last) begin
              idx <= '0;
              i   <= '0;
              j   <= '0;
              for (int n = 0; n < N; n++) r[n] <= '0;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        S_MAC: begin
          // LED shows the accumulator before this term lands in it.
          LED <= {4'h3, 4'(i), 8'(r[k])};
          if ((NEGA != 0) && wrap) r[k] <= r[k] - prod;
          else                     r[k] <= r[k] + prod;
          j <= (j == LAST) ? '0 : j + ONE;
          if (j == LAST) i <= (i == LAST) ? '0 : i + ONE;
        end
        S_DONE: begin
          LED <= {4'h4, bits[11:8], 8'(r[sel])};
          if (ld_edge) idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mult_harness.sv
// Randomised and directed check of poly_mult_harness against an arithmetic polynomial-product model.
// Four instances: N=4/W=4 and N=8/W=8, each in cyclic and negacyclic flavour.
module tb_poly_mult_harness;

  typedef int coef_t [16];

  logic        man_clk;
  logic        man_reset;
  logic [15:0] bits4, bits8;
  logic        load4, load8;
  logic [15:0] led4c, led4n, led8c, led8n;
  logic        done4c, done4n, done8c, done8n;

  int checks = 0;
  int errors = 0;

  poly_mult_harness #(.N(4), .W(4), .NEGA(0)) dut4c (
    .man_clk(man_clk), .man_reset(man_reset), .bits(bits4), .load(load4), .LED(led4c), .done(done4c));
  poly_mult_harness #(.N(4), .W(4), .NEGA(1)) dut4n (
    .man_clk(man_clk), .man_reset(man_reset), .bits(bits4), .load(load4), .LED(led4n), .done(done4n));
  poly_mult_harness #(.N(8), .W(8), .NEGA(0)) dut8c (
    .man_clk(man_clk), .man_reset(man_reset), .bits(bits8), .load(load8), .LED(led8c), .done(done8c));
  poly_mult_harness #(.N(8), .W(8), .NEGA(1)) dut8n (
    .man_clk(man_clk), .man_reset(man_reset), .bits(bits8), .load(load8), .LED(led8n), .done(done8n));

  initial man_clk = 1'b0;
  always #5 man_clk = ~man_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge man_clk);
    #1;
  endtask

  task automatic setInputs(input int grp, input logic [15:0] bv, input logic lv);
    if (grp == 0) begin bits4 = bv; load4 = lv; end
    else          begin bits8 = bv; load8 = lv; end
  endtask

  function automatic logic [15:0] getLed(input int grp, input int neg);
    if (grp == 0) return (neg != 0) ? led4n : led4c;
    return (neg != 0) ? led8n : led8c;
  endfunction

  function automatic logic getDone(input int grp, input int neg);
    if (grp == 0) return (neg != 0) ? done4n : done4c;
    return (neg != 0) ? done8n : done8c;
  endfunction

  // Product of two polynomials, reducing x^N to +1 or -1, then taken mod 2^W.
  task automatic refPoly(input int n, input int w, input bit nega, input coef_t av, input coef_t bv,
                         output coef_t rv);
    int acc [16];
    for (int q = 0; q < 16; q++) acc[q] = 0;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++) begin
        if (nega && (x + y >= n)) acc[(x + y) % n] -= av[x] * bv[y];
        else                      acc[(x + y) % n] += av[x] * bv[y];
      end
    for (int q = 0; q < 16; q++) rv[q] = (q < n) ? (acc[q] & ((1 << w) - 1)) : 0;
  endtask

  task automatic make4(output coef_t c, input int c0, input int c1, input int c2, input int c3);
    for (int q = 0; q < 16; q++) c[q] = 0;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
  endtask

  task automatic makeRandom(output coef_t c, input int n, input int w);
    for (int q = 0; q < 16; q++) c[q] = (q < n) ? int'($urandom_range(0, (1 << w) - 1)) : 0;
  endtask

  // One load press: a rising edge followed by a low cycle.
  task automatic applyStimulus(input int grp, input int val);
    setInputs(grp, 16'(val), 1'b1);
    tick();
    setInputs(grp, 16'(val), 1'b0);
    tick();
  endtask

  task automatic restartGroup(input int grp);
    setInputs(grp, 16'h0000, 1'b1);
    tick();
    checkOutput("restart_done_cyc", 32'(getDone(grp, 0)), 32'd0);
    checkOutput("restart_done_neg", 32'(getDone(grp, 1)), 32'd0);
    setInputs(grp, 16'h0000, 1'b0);
    tick();
    checkOutput("restart_state_cyc", 32'(getLed(grp, 0) >> 12), 32'd1);
    checkOutput("restart_state_neg", 32'(getLed(grp, 1) >> 12), 32'd1);
  endtask

  task automatic loadOperands(input int grp, input coef_t av, input coef_t bv, input bit hold_first);
    int n;
    n = (grp == 0) ? 4 : 8;
    for (int q = 0; q < n; q++) begin
      if (q == 0 && hold_first) begin
        setInputs(grp, 16'(av[0]), 1'b1);
        repeat (5) tick();
        setInputs(grp, 16'(av[0]), 1'b0);
        tick();
        checkOutput("hold_idx", 32'(getLed(grp, 0) >> 8) & 32'hF, 32'd1);
      end else begin
        applyStimulus(grp, av[q]);
      end
    end
    for (int q = 0; q < n - 1; q++) applyStimulus(grp, bv[q]);
    setInputs(grp, 16'(bv[n-1]), 1'b1);
    tick();
    setInputs(grp, 16'(bv[n-1]), 1'b0);
  endtask

  task automatic runProduct(input int grp, input coef_t av, input coef_t bv, input bit hold_first,
                            input bit pulse_mac);
    int n, w, cycles;
    coef_t rc, rn;
    n = (grp == 0) ? 4 : 8;
    w = (grp == 0) ? 4 : 8;
    refPoly(n, w, 1'b0, av, bv, rc);
    refPoly(n, w, 1'b1, av, bv, rn);
    loadOperands(grp, av, bv, hold_first);
    cycles = 0;
    while (!getDone(grp, 0) && cycles < n * n + 20) begin
      if (pulse_mac && cycles < n * n - 3) setInputs(grp, 16'h0000, (cycles % 2) == 0);
      else                                 setInputs(grp, 16'h0000, 1'b0);
      tick();
      cycles++;
    end
    setInputs(grp, 16'h0000, 1'b0);
    checkOutput("mac_latency", 32'(cycles), 32'(n * n));
    checkOutput("done_neg", 32'(getDone(grp, 1)), 32'd1);
    for (int q = 0; q < n; q++) begin
      setInputs(grp, 16'(q << 8), 1'b0);
      tick();
      checkOutput("result_cyc", 32'(getLed(grp, 0)), 32'h4000 | 32'(q << 8) | 32'(rc[q]));
      checkOutput("result_neg", 32'(getLed(grp, 1)), 32'h4000 | 32'(q << 8) | 32'(rn[q]));
    end
  endtask

  task automatic resetMidMac();
    coef_t av, bv;
    makeRandom(av, 4, 4);
    makeRandom(bv, 4, 4);
    loadOperands(0, av, bv, 1'b0);
    repeat (7) tick();
    man_reset = 1'b1;
    #1;
    checkOutput("midreset_led", 32'(led4c), 32'h0);
    checkOutput("midreset_done", 32'(done4c), 32'h0);
    tick();
    checkOutput("midreset_led_neg", 32'(led4n), 32'h0);
    man_reset = 1'b0;
    tick();
    checkOutput("midreset_init", 32'(led4c), 32'hFFFF);
    checkOutput("midreset_init8", 32'(led8c), 32'hFFFF);
    bits4 = 16'h0003;
    tick();
    checkOutput("midreset_loada", 32'(led4c), 32'h1003);
  endtask

  initial begin
    coef_t av, bv;
    man_reset = 1'b1;
    bits4 = 16'h0000; load4 = 1'b0;
    bits8 = 16'h0000; load8 = 1'b0;
    repeat (3) tick();
    checkOutput("reset_led", 32'(led4c), 32'h0);
    checkOutput("reset_done", 32'(done4c), 32'h0);
    checkOutput("reset_led8", 32'(led8n), 32'h0);

    bits4 = 16'h0005;
    bits8 = 16'h00A5;
    man_reset = 1'b0;
    tick();
    checkOutput("init_led", 32'(led4c), 32'hFFFF);
    tick();
    checkOutput("loada_led", 32'(led4c), 32'h1005);
    checkOutput("loada_led8", 32'(led8c), 32'h10A5);

    make4(av, 1, 2, 0, 0);
    make4(bv, 3, 1, 0, 0);
    runProduct(0, av, bv, 1'b1, 1'b1);
    bits4 = 16'h0100;
    tick();
    checkOutput("basic_led_sel1", 32'(led4c), 32'h4107);
    bits4 = 16'h0500;
    tick();
    checkOutput("sel_mod_n", 32'(led4c), 32'h4507);

    restartGroup(0);
    make4(av, 0, 0, 0, 1);
    make4(bv, 0, 1, 0, 0);
    runProduct(0, av, bv, 1'b0, 1'b0);
    bits4 = 16'h0000;
    tick();
    checkOutput("wrap_r0_neg", 32'(led4n), 32'h400F);

    restartGroup(0);
    make4(av, 15, 15, 15, 15);
    make4(bv, 15, 15, 15, 15);
    runProduct(0, av, bv, 1'b0, 1'b1);
    bits4 = 16'h0000;
    tick();
    checkOutput("ovf_r0_neg", 32'(led4n), 32'h400E);

    restartGroup(0);
    makeRandom(av, 4, 4);
    makeRandom(bv, 4, 4);
    runProduct(0, av, bv, 1'b0, 1'b1);

    restartGroup(0);
    resetMidMac();

    for (int t = 0; t < 3; t++) begin
      if (t != 0) restartGroup(1);
      makeRandom(av, 8, 8);
      makeRandom(bv, 8, 8);
      runProduct(1, av, bv, t == 0, t != 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
